// File: rtl/prci_rst_seq.sv
// prci_rst_seq: PRCI reset sequencer.
// Waits for stable sys/ddr PLL lock, then releases the debug reset and, one
// cycle later, the system reset. Watchdog/software requests pulse the system
// reset for a fixed width while the debug domain stays alive; lock loss drops
// back to the full power-up sequence. The last reset cause is held for the
// APB register file. All outputs come straight from flops.
module prci_rst_seq #(
    parameter int LOCK_DELAY  = 16,  // consecutive locked cycles before release (>=2)
    parameter int HOLD_CYCLES = 32,  // system-reset width for watchdog/software (>=2)
    parameter int CNT_WIDTH   = 8    // must hold max(LOCK_DELAY, HOLD_CYCLES)
) (
    input  logic       i_clk,
    input  logic       i_pwrreset,
    input  logic       i_sys_locked,
    input  logic       i_ddr_locked,
    input  logic       i_dmireset,
    input  logic       i_wdog_rst,
    input  logic       i_sw_rst,
    output logic       o_sys_rst,
    output logic       o_sys_nrst,
    output logic       o_dbg_nrst,
    output logic [1:0] o_state,
    output logic [1:0] o_rst_cause
);

    typedef enum logic [1:0] {
        ST_WAIT_LOCK = 2'd0,
        ST_DBG_REL   = 2'd1,
        ST_RUN       = 2'd2,
        ST_HOLD      = 2'd3
    } state_t;

    localparam logic [1:0] CAUSE_POR  = 2'd0;
    localparam logic [1:0] CAUSE_LOCK = 2'd1;
    localparam logic [1:0] CAUSE_WDOG = 2'd2;
    localparam logic [1:0] CAUSE_SW   = 2'd3;

    // Terminal counts: the transition fires on the last counted cycle, so the
    // number of cycles spent is exactly LOCK_DELAY / HOLD_CYCLES.
    localparam logic [CNT_WIDTH-1:0] LOCK_LAST = CNT_WIDTH'(LOCK_DELAY - 1);
    localparam logic [CNT_WIDTH-1:0] HOLD_LAST = CNT_WIDTH'(HOLD_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [1:0]           cause_q, cause_d;
    logic                 locked;
    logic                 sys_rst_d;
    logic                 dbg_nrst_d;

    assign locked      = i_sys_locked & i_ddr_locked;
    assign o_state     = state_q;
    assign o_rst_cause = cause_q;

    // State register: FSM state, shared counter, sticky cause and the output flops.
    always_ff @(posedge i_clk or posedge i_pwrreset) begin
        if (i_pwrreset) begin
            state_q    <= ST_WAIT_LOCK;
            cnt_q      <= '0;
            cause_q    <= CAUSE_POR;
            o_sys_rst  <= 1'b1;
            o_sys_nrst <= 1'b0;
            o_dbg_nrst <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cause_q    <= cause_d;
            o_sys_rst  <= sys_rst_d;
            o_sys_nrst <= ~sys_rst_d;
            o_dbg_nrst <= dbg_nrst_d;
        end
    end

    // Next-state logic: lock loss always wins, then watchdog, then software.
    // The counter is cleared on every state change so it never wraps, and the
    // cause is only written when a reset state is entered.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cause_d = cause_q;
        case (state_q)
            ST_WAIT_LOCK: begin
                if (!locked) begin
                    cnt_d = '0;
                end else if (cnt_q == LOCK_LAST) begin
                    state_d = ST_DBG_REL;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_DBG_REL: begin
                cnt_d = '0;
                if (!locked) begin
                    state_d = ST_WAIT_LOCK;
                    cause_d = CAUSE_LOCK;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                cnt_d = '0;
                if (!locked) begin
                    state_d = ST_WAIT_LOCK;
                    cause_d = CAUSE_LOCK;
                end else if (i_wdog_rst) begin
                    state_d = ST_HOLD;
                    cause_d = CAUSE_WDOG;
                end else if (i_sw_rst) begin
                    state_d = ST_HOLD;
                    cause_d = CAUSE_SW;
                end
            end
            ST_HOLD: begin
                // Further watchdog/software pulses are deliberately ignored here.
                if (!locked) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                    cause_d = CAUSE_LOCK;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_WAIT_LOCK;
                cnt_d   = '0;
            end
        endcase
    end

    // Output decode from the next state so the registered outputs line up with
    // the state register; debug-module reset masks the debug release one cycle late.
    always_comb begin
        sys_rst_d  = 1'b1;
        dbg_nrst_d = 1'b0;
        case (state_d)
            ST_WAIT_LOCK: begin
                sys_rst_d  = 1'b1;
                dbg_nrst_d = 1'b0;
            end
            ST_DBG_REL: begin
                sys_rst_d  = 1'b1;
                dbg_nrst_d = 1'b1;
            end
            ST_RUN: begin
                sys_rst_d  = 1'b0;
                dbg_nrst_d = 1'b1;
            end
            ST_HOLD: begin
                sys_rst_d  = 1'b1;
                dbg_nrst_d = 1'b1;
            end
            default: begin
                sys_rst_d  = 1'b1;
                dbg_nrst_d = 1'b0;
            end
        endcase
        if (i_dmireset) begin
            dbg_nrst_d = 1'b0;
        end
    end

endmodule

// File: tb/tb_prci_rst_seq.sv
// tb_prci_rst_seq: directed bench for the PRCI reset sequencer.
module tb_prci_rst_seq;

    logic       clk;
    logic       pwrreset;
    logic       sys_locked;
    logic       ddr_locked;
    logic       dmireset;
    logic       wdog_rst;
    logic       sw_rst;
    logic       sys_rst;
    logic       sys_nrst;
    logic       dbg_nrst;
    logic [1:0] state;
    logic [1:0] rst_cause;

    int checks;
    int failures;

    prci_rst_seq #(
        .LOCK_DELAY (16),
        .HOLD_CYCLES(32),
        .CNT_WIDTH  (8)
    ) dut (
        .i_clk       (clk),
        .i_pwrreset  (pwrreset),
        .i_sys_locked(sys_locked),
        .i_ddr_locked(ddr_locked),
        .i_dmireset  (dmireset),
        .i_wdog_rst  (wdog_rst),
        .i_sw_rst    (sw_rst),
        .o_sys_rst   (sys_rst),
        .o_sys_nrst  (sys_nrst),
        .o_dbg_nrst  (dbg_nrst),
        .o_state     (state),
        .o_rst_cause (rst_cause)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance n active edges, then settle 1 time unit past the edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Counts system-reset cycles of a HOLD that has already been observed for
    // 'seen' cycles; also tracks that the debug domain never drops.
    task automatic finish_hold(input string tag, input int seen);
        int  n;
        bit  dbg_ok;
        n      = seen;
        dbg_ok = 1'b1;
        while (sys_rst && n < 100) begin
            step(1);
            if (sys_rst) n++;
            if (!dbg_nrst) dbg_ok = 1'b0;
            if (sys_nrst === sys_rst) dbg_ok = 1'b0;
        end
        check({tag, "_len"}, n, 32);
        check({tag, "_dbg_high"}, int'(dbg_ok), 1);
        check({tag, "_back_run"}, int'(state), 2);
    endtask

    // Full relock from WAIT_LOCK with locks already high at this point.
    task automatic relock(input string tag);
        step(15);
        check({tag, "_dbg_pre"}, int'(dbg_nrst), 0);
        step(1);
        check({tag, "_dbg_rel"}, int'(dbg_nrst), 1);
        check({tag, "_st_dbg"}, int'(state), 1);
        check({tag, "_sys_held"}, int'(sys_rst), 1);
        step(1);
        check({tag, "_st_run"}, int'(state), 2);
        check({tag, "_sys_nrst"}, int'(sys_nrst), 1);
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        pwrreset   = 1'b1;
        sys_locked = 1'b1;
        ddr_locked = 1'b1;
        dmireset   = 1'b0;
        wdog_rst   = 1'b0;
        sw_rst     = 1'b0;
        step(3);

        // Reset state
        check("rst_sys_rst", int'(sys_rst), 1);
        check("rst_sys_nrst", int'(sys_nrst), 0);
        check("rst_dbg_nrst", int'(dbg_nrst), 0);
        check("rst_state", int'(state), 0);
        check("rst_cause", int'(rst_cause), 0);

        // Power-on sequence
        pwrreset = 1'b0;
        relock("por");
        check("por_sys_rst", int'(sys_rst), 0);
        check("por_cause", int'(rst_cause), 0);

        // Watchdog
        wdog_rst = 1'b1;
        step(1);
        wdog_rst = 1'b0;
        check("wd_state", int'(state), 3);
        check("wd_cause", int'(rst_cause), 2);
        check("wd_dbg", int'(dbg_nrst), 1);
        finish_hold("wd_hold", 1);

        // Simultaneous requests, then ignored software pulse mid-hold
        wdog_rst = 1'b1;
        sw_rst   = 1'b1;
        step(1);
        wdog_rst = 1'b0;
        sw_rst   = 1'b0;
        check("both_cause", int'(rst_cause), 2);
        step(4);
        sw_rst = 1'b1;
        step(1);
        sw_rst = 1'b0;
        check("both_cause_kept", int'(rst_cause), 2);
        finish_hold("both_hold", 6);

        // Software reset alone
        sw_rst = 1'b1;
        step(1);
        sw_rst = 1'b0;
        check("sw_cause", int'(rst_cause), 3);
        finish_hold("sw_hold", 1);

        // Lock loss in RUN
        sys_locked = 1'b0;
        step(1);
        check("ll_run_state", int'(state), 0);
        check("ll_run_sys_rst", int'(sys_rst), 1);
        check("ll_run_dbg", int'(dbg_nrst), 0);
        check("ll_run_cause", int'(rst_cause), 1);
        step(2);
        sys_locked = 1'b1;
        relock("ll_run_relock");
        check("ll_run_cause_kept", int'(rst_cause), 1);

        // Lock loss in HOLD, then a 1-cycle ddr glitch at lock count 10
        wdog_rst = 1'b1;
        step(1);
        wdog_rst = 1'b0;
        check("ll_hold_entry", int'(rst_cause), 2);
        step(3);
        ddr_locked = 1'b0;
        step(1);
        check("ll_hold_state", int'(state), 0);
        check("ll_hold_sys_rst", int'(sys_rst), 1);
        check("ll_hold_dbg", int'(dbg_nrst), 0);
        check("ll_hold_cause", int'(rst_cause), 1);
        ddr_locked = 1'b1;
        step(10);
        ddr_locked = 1'b0;
        step(1);
        ddr_locked = 1'b1;
        relock("glitch");

        // Lock loss during the single DBG_REL cycle
        sys_locked = 1'b0;
        step(1);
        sys_locked = 1'b1;
        step(16);
        check("dbgrel_state", int'(state), 1);
        sys_locked = 1'b0;
        step(1);
        check("dbgrel_ll_state", int'(state), 0);
        check("dbgrel_ll_dbg", int'(dbg_nrst), 0);
        check("dbgrel_ll_cause", int'(rst_cause), 1);
        sys_locked = 1'b1;
        relock("dbgrel_relock");

        // Debug-module reset for 3 cycles in RUN
        dmireset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1);
            check("dmi_dbg_low", int'(dbg_nrst), 0);
            check("dmi_sys_nrst", int'(sys_nrst), 1);
            check("dmi_state", int'(state), 2);
        end
        dmireset = 1'b0;
        step(1);
        check("dmi_dbg_back", int'(dbg_nrst), 1);

        // Power reset asserted mid-HOLD takes effect without a clock edge
        wdog_rst = 1'b1;
        step(1);
        wdog_rst = 1'b0;
        step(5);
        check("pr_in_hold", int'(state), 3);
        @(negedge clk);
        pwrreset = 1'b1;
        #1;
        check("pr_async_sys_rst", int'(sys_rst), 1);
        check("pr_async_sys_nrst", int'(sys_nrst), 0);
        check("pr_async_dbg", int'(dbg_nrst), 0);
        check("pr_async_state", int'(state), 0);
        check("pr_async_cause", int'(rst_cause), 0);
        step(2);
        check("pr_held_state", int'(state), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time limit so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
